vt_seq_gen_100110: RTL and testbench
====================================

Name: vt_seq_gen_100110

Overview:
- Serial pattern transmitter that drives the 100110 sequence onto a 1-bit serial line, MSB first.
- Emits a programmable number of back-to-back or gap-separated repetitions.
- Is the stimulus/transmit end for the team's serial sequence detectors, on the same i_SI-style 1-bit link.
- Raises a per-pattern last-bit marker aligned with a Mealy detector's detect output, so the two can be checked against each other directly.

Parameters:
- WIDTH, 6, pattern length in bits.
- PATTERN, 6'b100110, pattern shifted out, MSB first.
- CNT_W, 8, width of the repetition count.
- GAP_W, 4, width of the inter-pattern gap length.

Ports:
- i_clk  input  1  rising-edge clock
- i_rst  input  1  synchronous reset, active-high
- i_start  input  1  request pulse; sampled only in IDLE
- i_reps  input  CNT_W  number of pattern repetitions; latched on accepted i_start
- i_gap  input  GAP_W  number of idle 0 bits between repetitions; latched on accepted i_start
- o_SO  output  1  serial data out (registered)
- o_busy  output  1  high while bits or gaps are being emitted
- o_last  output  1  high during the cycle o_SO carries the final bit of each pattern
- o_done  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- Reset (synchronous, i_rst=1 at a rising edge):
  - state=IDLE; o_SO=0, o_busy=0, o_last=0, o_done=0; internal counters cleared.
  - Reset mid-operation aborts immediately: no o_done, no partial continuation.
- All outputs are registered. o_SO=0 whenever not in SHIFT.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - i_start=1 with i_reps>0 → SHIFT. Latch i_reps and i_gap; load PATTERN into the shift register.
  - i_start=1 with i_reps=0 → DONE (no bits emitted).
- SHIFT:
  - First pattern bit appears on o_SO in the cycle immediately after the accepting edge.
  - One bit per cycle, MSB first; bit counter runs 0..WIDTH-1.
  - On bit WIDTH-1, o_last=1 in the same cycle.
  - After bit WIDTH-1:
    - reps remaining > 1 and gap > 0 → GAP.
    - reps remaining > 1 and gap = 0 → reload PATTERN and stay in SHIFT (back-to-back, no bubble).
    - final repetition → DONE.
- GAP: emits exactly gap cycles of o_SO=0, o_busy=1, then reloads PATTERN and returns to SHIFT.
- DONE: one cycle; o_done=1, o_busy=0, then → IDLE.
- i_start is ignored in SHIFT, GAP and DONE. No queuing.
- o_busy is high in SHIFT and GAP only.
- Total o_busy cycles = reps*WIDTH + (reps-1)*gap.
- Rep counter decrements on each pattern's last bit; no wrap. Max reps = 2^CNT_W - 1.
- Simultaneous i_rst and i_start: reset wins.

Optional Feature:
- Macro: VT_SEQ_GEN_ERR_INJ_EN.
- When defined:
  - Adds input port i_err_inj (1 bit) and output o_err (1 bit, reset 0).
  - An i_err_inj pulse in any state sets a sticky flag.
  - The next pattern to start (or the current one if its last bit is not yet sent) has its last bit inverted.
  - o_err=1 alongside o_last for that bit; the flag then clears.
  - Flag is cleared by i_rst.
- When undefined: neither port exists and patterns are always exact.

Decomposition:
- Package vt_seq_pkg holds:
  - state encoding constants (IDLE/SHIFT/GAP/DONE, 2-bit);
  - default WIDTH and PATTERN (6'b100110), shared with the detector.
- One natural sub-module: vt_piso_shift, a WIDTH-bit parallel-load, MSB-first shift register with load/shift enables and a bit-count output; used by the FSM.

Test Plan:
- Reset, then i_start with i_reps=1, i_gap=0 → o_SO=1,0,0,1,1,0 on cycles 1–6 after accept; o_last only on cycle 6; o_done on cycle 7; o_busy high for exactly 6 cycles.
- i_reps=3, i_gap=0 → 18-bit stream 100110100110100110; o_last on cycles 6, 12, 18; a connected detector flags exactly on those cycles.
- i_reps=2, i_gap=3 → 100110 000 100110; o_busy=15 cycles; o_done on cycle 16.
- i_reps=0 → no o_busy; o_done pulse the cycle after accept; o_SO stays 0.
- Reset mid-stream (i_rst at bit 3 of rep 2 of 4) → next cycle all outputs 0; no o_done. A later i_start with i_reps=1 runs normally.
- i_start pulses during SHIFT/GAP ignored. With VT_SEQ_GEN_ERR_INJ_EN, i_err_inj before rep 2 of 2 → second pattern is 100111, o_err with o_last on cycle 12, detector flags only cycle 6.

Source files
------------

// File: rtl/vt_seq_gen_100110_pkg.sv
// Shared definitions for the 100110 serial pattern transmitter and its companion detectors.
// The optional error-injection feature is enabled by defining VT_SEQ_GEN_ERR_INJ_EN.
package vt_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int unsigned SEQ_WIDTH   = 6;
    localparam logic [5:0]  SEQ_PATTERN = 6'b100110;

    // Bit-counter width able to index every pattern bit (at least one bit wide).
    function automatic int unsigned bit_cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/vt_seq_gen_100110_if.sv
// Request/status bundle of the 100110 serial pattern transmitter.
// Error-injection signals exist only when VT_SEQ_GEN_ERR_INJ_EN is defined.
interface vt_seq_gen_100110_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP_W = 4
);
    logic             i_start;
    logic [CNT_W-1:0] i_reps;
    logic [GAP_W-1:0] i_gap;
    logic             o_SO;
    logic             o_busy;
    logic             o_last;
    logic             o_done;
`ifdef VT_SEQ_GEN_ERR_INJ_EN
    logic             i_err_inj;
    logic             o_err;

    modport master (
        output i_start, i_reps, i_gap, i_err_inj,
        input  o_SO, o_busy, o_last, o_done, o_err
    );
    modport slave (
        input  i_start, i_reps, i_gap, i_err_inj,
        output o_SO, o_busy, o_last, o_done, o_err
    );
`else
    modport master (
        output i_start, i_reps, i_gap,
        input  o_SO, o_busy, o_last, o_done
    );
    modport slave (
        input  i_start, i_reps, i_gap,
        output o_SO, o_busy, o_last, o_done
    );
`endif
endinterface

// File: rtl/vt_seq_gen_100110_piso.sv
// Parallel-load, MSB-first shift register; zeros shift in behind the data so the
// serial output falls to 0 on its own once the last bit has been shifted past.
module vt_piso_shift #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned BIT_CW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              flip_next,
    input  logic [WIDTH-1:0]  load_value,
    output logic              serial,
    output logic [BIT_CW-1:0] bit_cnt
);

    localparam logic [BIT_CW-1:0] LAST_IDX = BIT_CW'(WIDTH - 1);

    logic [WIDTH-1:0]  data_r;
    logic [BIT_CW-1:0] cnt_r;

    // Shift register and bit index; flip_next inverts the bit that becomes visible next.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= {WIDTH{1'b0}};
            cnt_r  <= {BIT_CW{1'b0}};
        end else if (load) begin
            data_r <= load_value;
            cnt_r  <= {BIT_CW{1'b0}};
        end else if (shift) begin
            data_r <= {data_r[WIDTH-2:0], 1'b0} ^ {flip_next, {(WIDTH-1){1'b0}}};
            cnt_r  <= (cnt_r == LAST_IDX) ? cnt_r : cnt_r + 1'b1;
        end else begin
            data_r <= data_r;
            cnt_r  <= cnt_r;
        end
    end

    assign serial  = data_r[WIDTH-1];
    assign bit_cnt = cnt_r;

endmodule

// File: rtl/vt_seq_gen_100110.sv
// Serial transmitter emitting a programmable number of 100110 patterns, optionally gap-separated.
// Define VT_SEQ_GEN_ERR_INJ_EN to add last-bit error injection (i_err_inj / o_err).
module vt_seq_gen_100110
    import vt_seq_pkg::*;
#(
    parameter int unsigned      WIDTH   = SEQ_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN = SEQ_PATTERN,
    parameter int unsigned      CNT_W   = 8,
    parameter int unsigned      GAP_W   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    vt_seq_gen_100110_if.slave    bus
);

    localparam int unsigned       BIT_CW       = bit_cnt_width(WIDTH);
    localparam logic [BIT_CW-1:0] LAST_IDX     = BIT_CW'(WIDTH - 1);
    localparam logic [BIT_CW-1:0] PRE_LAST_IDX = BIT_CW'(WIDTH - 2);

    seq_state_t        state_r;
    logic [CNT_W-1:0]  reps_r;
    logic [GAP_W-1:0]  gap_len_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic              load_s;
    logic              shift_s;
    logic              flip_s;
    logic [BIT_CW-1:0] bit_cnt_s;
    logic              serial_s;
`ifdef VT_SEQ_GEN_ERR_INJ_EN
    logic              err_flag_r;
`endif

    vt_piso_shift #(
        .WIDTH  (WIDTH),
        .BIT_CW (BIT_CW)
    ) u_piso (
        .clk        (i_clk),
        .rst        (i_rst),
        .load       (load_s),
        .shift      (shift_s),
        .flip_next  (flip_s),
        .load_value (PATTERN),
        .serial     (serial_s),
        .bit_cnt    (bit_cnt_s)
    );

    // The shifter's MSB is a flop cleared outside SHIFT, so o_SO stays registered.
    assign bus.o_SO = serial_s;

    // Shifter control: load at each pattern start, otherwise shift while emitting.
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        flip_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start && (bus.i_reps != {CNT_W{1'b0}})) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                if ((bit_cnt_s == LAST_IDX) && (reps_r > CNT_W'(1)) &&
                    (gap_len_r == {GAP_W{1'b0}})) begin
                    load_s = 1'b1;
                end else begin
                    shift_s = 1'b1;
                end
`ifdef VT_SEQ_GEN_ERR_INJ_EN
                // A pending or same-cycle injection corrupts the bit about to become the last one.
                if ((bit_cnt_s == PRE_LAST_IDX) && (err_flag_r || bus.i_err_inj)) begin
                    flip_s = 1'b1;
                end else begin
                    flip_s = 1'b0;
                end
`endif
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_W'(1)) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_DONE: begin
                load_s = 1'b0;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Sequencing FSM with registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            reps_r     <= {CNT_W{1'b0}};
            gap_len_r  <= {GAP_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
            bus.o_busy <= 1'b0;
            bus.o_last <= 1'b0;
            bus.o_done <= 1'b0;
`ifdef VT_SEQ_GEN_ERR_INJ_EN
            bus.o_err  <= 1'b0;
            err_flag_r <= 1'b0;
`endif
        end else begin
`ifdef VT_SEQ_GEN_ERR_INJ_EN
            if (flip_s) begin
                err_flag_r <= 1'b0;
            end else if (bus.i_err_inj) begin
                err_flag_r <= 1'b1;
            end else begin
                err_flag_r <= err_flag_r;
            end
            bus.o_err <= flip_s;
`endif
            case (state_r)
                ST_IDLE: begin
                    bus.o_last <= 1'b0;
                    if (bus.i_start) begin
                        reps_r    <= bus.i_reps;
                        gap_len_r <= bus.i_gap;
                        if (bus.i_reps != {CNT_W{1'b0}}) begin
                            state_r    <= ST_SHIFT;
                            bus.o_busy <= 1'b1;
                            bus.o_done <= 1'b0;
                        end else begin
                            state_r    <= ST_DONE;
                            bus.o_busy <= 1'b0;
                            bus.o_done <= 1'b1;
                        end
                    end else begin
                        state_r    <= ST_IDLE;
                        bus.o_busy <= 1'b0;
                        bus.o_done <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    bus.o_last <= (bit_cnt_s == PRE_LAST_IDX);
                    if (bit_cnt_s == LAST_IDX) begin
                        reps_r <= reps_r - 1'b1;
                        if (reps_r > CNT_W'(1)) begin
                            if (gap_len_r != {GAP_W{1'b0}}) begin
                                state_r   <= ST_GAP;
                                gap_cnt_r <= gap_len_r;
                            end else begin
                                state_r <= ST_SHIFT;
                            end
                        end else begin
                            state_r    <= ST_DONE;
                            bus.o_busy <= 1'b0;
                            bus.o_done <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_GAP: begin
                    bus.o_last <= 1'b0;
                    if (gap_cnt_r == GAP_W'(1)) begin
                        state_r <= ST_SHIFT;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    bus.o_busy <= 1'b0;
                    bus.o_last <= 1'b0;
                    bus.o_done <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    bus.o_busy <= 1'b0;
                    bus.o_last <= 1'b0;
                    bus.o_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vt_seq_gen_100110.sv
// Scoreboard bench for vt_seq_gen_100110: expected per-cycle output records are queued at
// each accepted start and a monitor process compares them against the DUT every active cycle.
module tb_vt_seq_gen_100110;
    import vt_seq_pkg::*;

    localparam int PW = 6;

    typedef struct packed {
        logic so;
        logic busy;
        logic last;
        logic done;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t sb_q[$];

    vt_seq_gen_100110_if #(.CNT_W(8), .GAP_W(4)) bus ();

    vt_seq_gen_100110 dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each repetition is the pattern MSB first, gaps are zeros, then one done cycle.
    task automatic push_expected(input int reps, input int gap);
        logic [PW-1:0] pat;
        rec_t r;
        pat = SEQ_PATTERN;
        for (int i = 0; i < reps; i++) begin
            for (int b = 0; b < PW; b++) begin
                r = '{so: pat[PW-1-b], busy: 1'b1, last: (b == PW-1), done: 1'b0};
                sb_q.push_back(r);
            end
            if (i < reps - 1) begin
                for (int g = 0; g < gap; g++) begin
                    r = '{so: 1'b0, busy: 1'b1, last: 1'b0, done: 1'b0};
                    sb_q.push_back(r);
                end
            end
        end
        r = '{so: 1'b0, busy: 1'b0, last: 1'b0, done: 1'b1};
        sb_q.push_back(r);
    endtask

    // Monitor: compare every active cycle with the scoreboard; an ideal detector tracks o_SO.
    initial begin
        logic [PW-1:0] hist;
        logic [PW-1:0] pat;
        rec_t act;
        rec_t exp;
        hist = '0;
        pat  = SEQ_PATTERN;
        forever begin
            @(negedge clk);
            hist = {hist[PW-2:0], bus.o_SO};
            act  = '{so: bus.o_SO, busy: bus.o_busy, last: bus.o_last, done: bus.o_done};
            if (bus.o_busy === 1'b1 || bus.o_done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_activity", 32'(act), 32'(4'b0000));
                end else begin
                    exp = sb_q.pop_front();
                    check("stream", 32'(act), 32'(exp));
                    if (bus.o_busy === 1'b1) begin
                        check("detector_vs_last", 32'(hist == pat), 32'(bus.o_last));
                    end
                end
            end else if (chk_en) begin
                check("idle_quiet", 32'({bus.o_SO, bus.o_last}), 32'(2'b00));
            end
        end
    end

    // One transaction: start, latency check, bounded wait for done, busy length, DONE-time start ignored.
    task automatic run_txn(input int reps, input int gap, input bit noise);
        int budget;
        int busy_cnt;
        int cyc;
        bit seen_done;
        bus.i_start = 1'b1;
        bus.i_reps  = 8'(reps);
        bus.i_gap   = 4'(gap);
        push_expected(reps, gap);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check("first_cycle_busy", 32'(bus.o_busy), 32'(reps != 0));
        check("first_cycle_done", 32'(bus.o_done), 32'(reps == 0));
        budget    = reps * PW + ((reps > 0) ? (reps - 1) * gap : 0) + 4;
        busy_cnt  = 0;
        seen_done = 1'b0;
        cyc       = 0;
        while (cyc < budget && !seen_done) begin
            if (bus.o_busy === 1'b1) busy_cnt++;
            if (bus.o_done === 1'b1) begin
                seen_done = 1'b1;
            end else begin
                if (noise) begin
                    bus.i_start = ($urandom_range(0, 3) == 0);
                    bus.i_reps  = 8'($urandom_range(1, 9));
                    bus.i_gap   = 4'($urandom_range(0, 15));
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("done_seen", 32'(seen_done), 32'(1));
        check("busy_cycles", 32'(busy_cnt),
              32'(reps * PW + ((reps > 0) ? (reps - 1) * gap : 0)));
        // A start raised during the DONE cycle must be ignored.
        bus.i_start = noise;
        bus.i_reps  = 8'd3;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_start   = 1'b0;
        bus.i_reps    = 8'd0;
        bus.i_gap     = 4'd0;
`ifdef VT_SEQ_GEN_ERR_INJ_EN
        bus.i_err_inj = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({bus.o_SO, bus.o_busy, bus.o_last, bus.o_done}), 32'(4'b0000));
        // Reset wins over a simultaneous start.
        bus.i_start = 1'b1;
        bus.i_reps  = 8'd2;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check("reset_beats_start", 32'({bus.o_busy, bus.o_done}), 32'(2'b00));
        rst    = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 0, 1'b0);
        run_txn(3, 0, 1'b1);
        run_txn(2, 3, 1'b1);
        run_txn(0, 5, 1'b1);
        run_txn(2, 15, 1'b0);
        run_txn(255, 1, 1'b0);
        for (int t = 0; t < 25; t++) begin
            run_txn(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Abort with reset while bit index 3 of repetition 2 of 4 is on the line.
        begin
            bit any_act;
            bus.i_start = 1'b1;
            bus.i_reps  = 8'd4;
            bus.i_gap   = 4'd2;
            push_expected(4, 2);
            @(posedge clk); #1;
            bus.i_start = 1'b0;
            repeat (PW + 2 + 3) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk); #1;
            check("abort_outputs", 32'({bus.o_SO, bus.o_busy, bus.o_last, bus.o_done}), 32'(4'b0000));
            sb_q.delete();
            rst     = 1'b0;
            any_act = 1'b0;
            repeat (10) begin
                @(posedge clk); #1;
                if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) any_act = 1'b1;
            end
            check("abort_no_done", 32'(any_act), 32'(0));
        end
        run_txn(1, 0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
